length_envelope_bank: RTL and testbench

Parametrised bank of per-channel length counters and volume envelopes with an internal frame sequencer. Generalises the fixed four-channel length gate to NUM_CH channels. Adds NES-accurate envelope decay, 4-step/5-step sequencing, and registered channel outputs. Sits between the waveform generators (square/triangle/noise) and the mixer table lookup.

---
 rtl/length_envelope_bank_if.sv | 29 ++
 rtl/length_envelope_bank.sv | 153 +++++++++++++++
 tb/tb_length_envelope_bank.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/length_envelope_bank_if.sv
// Register-write, channel-control and gated-volume signals of the length/envelope bank.
// Latency: none, wires only.
// Backpressure: none; writes are single-cycle strobes that are always accepted.
interface length_envelope_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
);
    logic                  wr_en;
    logic [CH_W-1:0]       wr_ch;
    logic                  wr_sel;
    logic [7:0]            wr_data;
    logic [NUM_CH-1:0]     ch_enable;
    logic                  seq_mode;
    logic [NUM_CH-1:0]     wave_in;
    logic [4*NUM_CH-1:0]   sound_out;
    logic [NUM_CH-1:0]     length_active;
    logic                  quarter_tick;
    logic                  half_tick;

    modport master (
        output wr_en, wr_ch, wr_sel, wr_data, ch_enable, seq_mode, wave_in,
        input  sound_out, length_active, quarter_tick, half_tick
    );

    modport slave (
        input  wr_en, wr_ch, wr_sel, wr_data, ch_enable, seq_mode, wave_in,
        output sound_out, length_active, quarter_tick, half_tick
    );
endinterface

// File: rtl/length_envelope_bank.sv
// Per-channel length counters and volume envelopes driven by a 4/5-step frame sequencer.
// Latency: sound_out one cycle after wave_in/state; ticks decode directly from sequencer state.
// Backpressure: none; every write and tick is consumed in the cycle it occurs.
module length_envelope_bank #(
    parameter int NUM_CH   = 4,
    parameter int CH_W     = 2,
    parameter int TICK_DIV = 7457
) (
    input  logic                  clk,
    input  logic                  rst_n,
    length_envelope_bank_if.slave bus
);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [7:0] LEN_TABLE [32] = '{
        8'd10,  8'd254, 8'd20,  8'd2,   8'd40,  8'd4,   8'd80,  8'd6,
        8'd160, 8'd8,   8'd60,  8'd10,  8'd14,  8'd12,  8'd26,  8'd14,
        8'd12,  8'd16,  8'd24,  8'd18,  8'd48,  8'd20,  8'd96,  8'd22,
        8'd192, 8'd24,  8'd72,  8'd26,  8'd16,  8'd28,  8'd32,  8'd30
    };

    logic [PRE_W-1:0] prescaler;
    logic [2:0]       step;
    logic             mode_q;
    logic [2:0]       step_nxt;
    logic             mode_chg;
    logic             wrap;
    logic             q_tick;
    logic             h_tick;

    assign mode_chg = bus.seq_mode != mode_q;
    assign wrap     = prescaler == PRE_LAST;
    assign step_nxt = (step == (mode_q ? 3'd4 : 3'd3)) ? 3'd0 : step + 3'd1;

    // Ticks belong to the step being entered; a mode change swallows the wrap entirely.
    always_comb begin
        q_tick = 1'b0;
        h_tick = 1'b0;
        if (wrap && !mode_chg) begin
            if (mode_q) begin
                q_tick = step_nxt != 3'd3;
                h_tick = (step_nxt == 3'd1) || (step_nxt == 3'd4);
            end else begin
                q_tick = 1'b1;
                h_tick = (step_nxt == 3'd1) || (step_nxt == 3'd3);
            end
        end
    end

    assign bus.quarter_tick = q_tick;
    assign bus.half_tick    = h_tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            step      <= 3'd0;
            mode_q    <= 1'b0;
        end else begin
            mode_q <= bus.seq_mode;
            if (mode_chg) begin
                prescaler <= '0;
                step      <= 3'd0;
            end else if (wrap) begin
                prescaler <= '0;
                step      <= step_nxt;
            end else begin
                prescaler <= prescaler + PRE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Control bits 7:6 have no function, so only bits 5:0 are kept.
        logic [5:0] ctrl;
        logic [7:0] len;
        logic [7:0] len_nxt;
        logic       start;
        logic [3:0] decay;
        logic [3:0] divider;
        logic [3:0] sound_q;
        logic       active_q;
        logic       sel_hit;
        logic       ctrl_wr;
        logic       len_wr;
        logic       halt;
        logic       const_vol;
        logic [3:0] vol;

        assign sel_hit   = bus.wr_en && (bus.wr_ch == CH_W'(i));
        assign ctrl_wr   = sel_hit && !bus.wr_sel;
        assign len_wr    = sel_hit && bus.wr_sel;
        assign halt      = ctrl[5];
        assign const_vol = ctrl[4];
        assign vol       = ctrl[3:0];

        // Disable beats a load, and a load beats a same-cycle decrement.
        always_comb begin
            len_nxt = len;
            if (!bus.ch_enable[i]) begin
                len_nxt = 8'd0;
            end else if (len_wr) begin
                len_nxt = LEN_TABLE[bus.wr_data[7:3]];
            end else if (h_tick && !halt && (len != 8'd0)) begin
                len_nxt = len - 8'd1;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl     <= 6'd0;
                len      <= 8'd0;
                start    <= 1'b0;
                decay    <= 4'd0;
                divider  <= 4'd0;
                sound_q  <= 4'd0;
                active_q <= 1'b0;
            end else begin
                if (ctrl_wr) begin
                    ctrl <= bus.wr_data[5:0];
                end
                len <= len_nxt;

                if (q_tick) begin
                    if (start) begin
                        start   <= 1'b0;
                        decay   <= 4'd15;
                        divider <= vol;
                    end else if (divider == 4'd0) begin
                        divider <= vol;
                        if (decay != 4'd0) begin
                            decay <= decay - 4'd1;
                        end else if (halt) begin
                            decay <= 4'd15;
                        end
                    end else begin
                        divider <= divider - 4'd1;
                    end
                end
                // A fresh length write re-arms the envelope even if it lands on a quarter tick.
                if (len_wr) begin
                    start <= 1'b1;
                end

                sound_q  <= ((len != 8'd0) && bus.wave_in[i]) ? (const_vol ? vol : decay) : 4'd0;
                active_q <= len_nxt != 8'd0;
            end
        end

        assign bus.sound_out[4*i +: 4] = sound_q;
        assign bus.length_active[i]    = active_q;
    end
endmodule

// File: tb/tb_length_envelope_bank.sv
// Directed bench for length_envelope_bank with a queued scoreboard and a negedge monitor.
// Latency: expectations are pushed in the cycle they apply and popped on that cycle's negedge.
// Backpressure: none; every tick wait is bounded by a cycle budget.
module tb_length_envelope_bank;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;
    localparam int T      = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    length_envelope_bank_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus ();

    length_envelope_bank #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TICK_DIV(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef enum int {K_SOUND, K_ACTIVE, K_SALL, K_AALL, K_TICKS, K_QCNT, K_HCNT, K_WAIT} kind_e;
    typedef struct {
        kind_e kind;
        int    idx;
        int    exp;
        int    bench_val;
        string name;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int q_total  = 0;
    int h_total  = 0;

    function automatic void expect_v(kind_e k, int idx, int exp, string name);
        exp_t e;
        e.kind = k;
        e.idx = idx;
        e.exp = exp;
        e.bench_val = 0;
        e.name = name;
        sb.push_back(e);
    endfunction

    always @(negedge clk) begin
        int   act;
        exp_t e;
        if (bus.quarter_tick) q_total = q_total + 1;
        if (bus.half_tick)    h_total = h_total + 1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                K_SOUND:  act = int'(bus.sound_out[4*e.idx +: 4]);
                K_ACTIVE: act = int'(bus.length_active[e.idx[1:0]]);
                K_SALL:   act = int'(bus.sound_out);
                K_AALL:   act = int'(bus.length_active);
                K_TICKS:  act = int'({bus.quarter_tick, bus.half_tick});
                K_QCNT:   act = q_total;
                K_HCNT:   act = h_total;
                default:  act = e.bench_val;
            endcase
            checks = checks + 1;
            if (act != e.exp) begin
                failures = failures + 1;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns in the cycle just after the n-th observed tick of the chosen kind.
    task automatic wait_tick(input bit half, input int n);
        int seen = 0;
        int budget = 0;
        while (seen < n && budget < n * 4 * T + 8) begin
            if (half ? bus.half_tick : bus.quarter_tick) seen++;
            cyc(1);
            budget++;
        end
        checks = checks + 1;
        if (seen < n) begin
            failures = failures + 1;
            $display("FAIL tick_wait_timeout: saw %0d of %0d ticks", seen, n);
        end
    endtask

    task automatic wr(input int ch, input bit sel, input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_ch   = CH_W'(ch);
        bus.wr_sel  = sel;
        bus.wr_data = d;
        cyc(1);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        int qb;
        int hb;
        bus.wr_en = 1'b0;
        bus.wr_ch = '0;
        bus.wr_sel = 1'b0;
        bus.wr_data = 8'h00;
        bus.ch_enable = '0;
        bus.seq_mode = 1'b0;
        bus.wave_in = '0;

        // Reset state and idle 4-step frame
        cyc(3);
        checks = checks + 1;
        if (bus.sound_out !== '0 || bus.length_active !== '0 ||
            bus.quarter_tick !== 1'b0 || bus.half_tick !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL reset_state_direct: sound=%0h active=%0h q=%0b h=%0b",
                     bus.sound_out, bus.length_active, bus.quarter_tick, bus.half_tick);
        end
        expect_v(K_SALL, 0, 0, "reset_sound");
        expect_v(K_AALL, 0, 0, "reset_active");
        expect_v(K_TICKS, 0, 0, "reset_ticks");
        rst_n = 1'b1;
        qb = q_total;
        hb = h_total;
        cyc(T - 2);
        expect_v(K_TICKS, 0, 0, "no_tick_before_first");
        cyc(1);
        expect_v(K_TICKS, 0, 3, "first_tick_q_h");
        cyc(3 * T);
        expect_v(K_QCNT, 0, qb + 4, "idle_quarter_count");
        expect_v(K_HCNT, 0, hb + 2, "idle_half_count");
        expect_v(K_SALL, 0, 0, "idle_sound");
        expect_v(K_AALL, 0, 0, "idle_active");
        cyc(1);

        // Out-of-range channel write must not alias onto ch0
        bus.ch_enable = 4'b0001;
        bus.wave_in = 4'b0001;
        wr(4, 1'b1, 8'h08);
        expect_v(K_ACTIVE, 0, 0, "bad_ch_ignored");

        // ch0 constant volume 0xA, length 254
        wr(0, 1'b0, 8'h1A);
        wr(0, 1'b1, 8'h08);
        expect_v(K_ACTIVE, 0, 1, "ch0_loaded");
        cyc(1);
        expect_v(K_SOUND, 0, 10, "ch0_const_vol");
        wait_tick(1'b1, 253);
        expect_v(K_ACTIVE, 0, 1, "ch0_after_253_half");
        wait_tick(1'b1, 1);
        expect_v(K_ACTIVE, 0, 0, "ch0_after_254_half");
        cyc(1);
        expect_v(K_SOUND, 0, 0, "ch0_sound_gated");

        // ch1 decaying envelope, period 3, length 10
        bus.ch_enable = 4'b0011;
        bus.wave_in = 4'b0011;
        wr(1, 1'b0, 8'h03);
        wr(1, 1'b1, 8'h00);
        cyc(1);
        expect_v(K_SOUND, 1, 0, "ch1_before_first_quarter");
        wait_tick(1'b0, 1);
        cyc(1);
        expect_v(K_SOUND, 1, 15, "ch1_start_15");
        wait_tick(1'b0, 3);
        cyc(1);
        expect_v(K_SOUND, 1, 15, "ch1_hold_15_q4");
        wait_tick(1'b0, 1);
        cyc(1);
        expect_v(K_SOUND, 1, 14, "ch1_decay_14_q5");
        expect_v(K_ACTIVE, 1, 1, "ch1_active");

        // ch1 looping envelope with halted length
        wr(1, 1'b0, 8'h23);
        wr(1, 1'b1, 8'h00);
        wait_tick(1'b0, 1);
        cyc(1);
        expect_v(K_SOUND, 1, 15, "loop_start_15");
        wait_tick(1'b0, 60);
        cyc(1);
        expect_v(K_SOUND, 1, 0, "loop_decay_0_q61");
        wait_tick(1'b0, 3);
        cyc(1);
        expect_v(K_SOUND, 1, 0, "loop_still_0_q64");
        wait_tick(1'b0, 1);
        cyc(1);
        expect_v(K_SOUND, 1, 15, "loop_wrap_15_q65");
        expect_v(K_ACTIVE, 1, 1, "halt_keeps_length");

        // ch2 period 0, no loop: decays one per quarter and sticks at 0
        bus.ch_enable = 4'b0111;
        bus.wave_in = 4'b0111;
        wr(2, 1'b0, 8'h00);
        wr(2, 1'b1, 8'h08);
        wait_tick(1'b0, 1);
        cyc(1);
        expect_v(K_SOUND, 2, 15, "ch2_start_15");
        wait_tick(1'b0, 14);
        cyc(1);
        expect_v(K_SOUND, 2, 1, "ch2_decay_1_q15");
        wait_tick(1'b0, 1);
        cyc(1);
        expect_v(K_SOUND, 2, 0, "ch2_decay_0_q16");
        wait_tick(1'b0, 4);
        cyc(1);
        expect_v(K_SOUND, 2, 0, "ch2_holds_0");

        // 5-step sequence
        bus.seq_mode = 1'b1;
        qb = q_total;
        hb = h_total;
        cyc(T);
        expect_v(K_TICKS, 0, 3, "5step_s1_q_h");
        cyc(T);
        expect_v(K_TICKS, 0, 2, "5step_s2_q");
        cyc(T);
        expect_v(K_TICKS, 0, 0, "5step_s3_silent");
        cyc(T);
        expect_v(K_TICKS, 0, 3, "5step_s4_q_h");
        cyc(T);
        expect_v(K_TICKS, 0, 2, "5step_s0_q");
        expect_v(K_QCNT, 0, qb + 4, "5step_quarter_count");
        expect_v(K_HCNT, 0, hb + 2, "5step_half_count");

        // Mid-count toggle restarts the prescaler
        cyc(5);
        bus.seq_mode = 1'b0;
        cyc(T - 1);
        expect_v(K_TICKS, 0, 0, "toggle_no_early_tick");
        cyc(1);
        expect_v(K_TICKS, 0, 3, "toggle_next_tick");
        cyc(T);
        bus.seq_mode = 1'b1;
        expect_v(K_TICKS, 0, 0, "toggle_on_wrap_suppressed");
        cyc(1);
        bus.seq_mode = 1'b0;

        // Length load coincident with half tick: load wins
        bus.ch_enable = 4'b1111;
        bus.wave_in = 4'b1111;
        cyc(1);
        wr(3, 1'b0, 8'h00);
        cyc(T - 2);
        expect_v(K_TICKS, 0, 3, "coincident_half_tick");
        wr(3, 1'b1, 8'h18);
        expect_v(K_ACTIVE, 3, 1, "coincident_loaded");
        wait_tick(1'b1, 1);
        expect_v(K_ACTIVE, 3, 1, "coincident_len_1_left");
        wait_tick(1'b1, 1);
        expect_v(K_ACTIVE, 3, 0, "coincident_len_expired");

        // Load while disabled, then disable with length 30
        bus.ch_enable = 4'b0111;
        wr(3, 1'b1, 8'h08);
        expect_v(K_ACTIVE, 3, 0, "load_while_disabled");
        bus.ch_enable = 4'b1111;
        cyc(1);
        expect_v(K_ACTIVE, 3, 0, "still_empty_after_enable");
        wr(3, 1'b1, 8'hF8);
        expect_v(K_ACTIVE, 3, 1, "len30_loaded");
        bus.ch_enable = 4'b0111;
        cyc(1);
        expect_v(K_ACTIVE, 3, 0, "disable_clears_length");

        // Reset mid-operation
        rst_n = 1'b0;
        expect_v(K_SALL, 0, 0, "midreset_sound");
        expect_v(K_AALL, 0, 0, "midreset_active");
        expect_v(K_TICKS, 0, 0, "midreset_ticks");
        cyc(2);
        rst_n = 1'b1;
        cyc(T - 1);
        expect_v(K_TICKS, 0, 3, "post_reset_first_tick");
        expect_v(K_SALL, 0, 0, "post_reset_sound");
        expect_v(K_AALL, 0, 0, "post_reset_active");

        cyc(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
